// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: write-back source select and load types.
package pipe_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4,
        LD_D  = 3'd5
    } load_type_e;

endpackage

// File: rtl/load_align.sv
// Combinational sub-word load extraction with sign/zero extension and
// alignment checking. Unsupported load types return zero and flag o_invalid.
module load_align
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      i_load_type,
    input  logic [2:0]      i_addr_lsb,
    input  logic [XLEN-1:0] i_read_data,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign,
    output logic            o_invalid
);

    // Only the byte offsets inside one XLEN word are meaningful.
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    logic [OFF_W-1:0] w_off;
    logic [XLEN-1:0]  w_shift;

    assign w_off   = i_addr_lsb[OFF_W-1:0];
    assign w_shift = i_read_data >> {w_off, 3'b000};

    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        o_invalid  = 1'b0;
        case (i_load_type)
            LD_B:  o_data = XLEN'($signed(w_shift[7:0]));
            LD_BU: o_data = XLEN'(w_shift[7:0]);
            LD_H: begin
                o_data     = XLEN'($signed(w_shift[15:0]));
                o_misalign = i_addr_lsb[0];
            end
            LD_HU: begin
                o_data     = XLEN'(w_shift[15:0]);
                o_misalign = i_addr_lsb[0];
            end
            LD_W: begin
                o_data     = XLEN'($signed(w_shift[31:0]));
                o_misalign = |i_addr_lsb[1:0];
            end
            LD_D: begin
                if (XLEN == 64) begin
                    o_data     = w_shift;
                    o_misalign = |i_addr_lsb;
                end else begin
                    o_invalid = 1'b1;
                end
            end
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with write-back source select and load alignment.
// Define WB_BYPASS_EN to add a second stage holding the last committed write.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int RADDR_W = 5,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic [SEL_W-1:0]   wb_sel,
    input  logic [2:0]         load_type,
    input  logic [2:0]         addr_lsb,
    input  logic [XLEN-1:0]    read_data,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    pc_plus4,
    input  logic [XLEN-1:0]    imm,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               reg_write_in,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               misalign
`ifdef WB_BYPASS_EN
    ,
    output logic               byp_valid,
    output logic [RADDR_W-1:0] byp_rd,
    output logic [XLEN-1:0]    byp_data
`endif
);

    logic [XLEN-1:0] w_ld_data;
    logic            w_ld_misalign;
    logic            w_ld_invalid;
    logic [XLEN-1:0] w_wdata;
    logic            w_is_load;
    logic            w_misalign;
    logic            w_live;
    logic            w_we;
    logic            w_cap;

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_load_type (load_type),
        .i_addr_lsb  (addr_lsb),
        .i_read_data (read_data),
        .o_data      (w_ld_data),
        .o_misalign  (w_ld_misalign),
        .o_invalid   (w_ld_invalid)
    );

    always_comb begin
        w_wdata = alu_result;
        case (wb_sel)
            WB_ALU:  w_wdata = alu_result;
            WB_MEM:  w_wdata = w_ld_data;
            WB_PC4:  w_wdata = pc_plus4;
            WB_IMM:  w_wdata = imm;
            default: w_wdata = alu_result;
        endcase
    end

    assign w_is_load  = (wb_sel == WB_MEM);
    assign w_misalign = w_is_load & w_ld_misalign;
    assign w_live     = in_valid & ~flush;
    assign w_we       = w_live & reg_write_in & (rd_in != '0)
                        & ~w_misalign & ~(w_is_load & w_ld_invalid);
    // Flush overrides stall so a squashed instruction never lingers.
    assign w_cap      = ~stall | flush;
    assign in_ready   = ~stall;

    logic               r_valid;
    logic               r_we;
    logic               r_misalign;
    logic [RADDR_W-1:0] r_rd;
    logic [XLEN-1:0]    r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_rd       <= '0;
            r_data     <= '0;
        end else if (w_cap) begin
            r_valid    <= w_live;
            r_we       <= w_we;
            r_misalign <= w_live & w_misalign;
            if (w_live) begin
                r_rd   <= rd_in;
                r_data <= w_wdata;
            end
        end
    end

    assign wb_valid = r_valid;
    assign wb_we    = r_we;
    assign wb_rd    = r_rd;
    assign wb_data  = r_data;
    assign misalign = r_misalign;

`ifdef WB_BYPASS_EN
    logic               r_byp_valid;
    logic [RADDR_W-1:0] r_byp_rd;
    logic [XLEN-1:0]    r_byp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_valid <= 1'b0;
            r_byp_rd    <= '0;
            r_byp_data  <= '0;
        end else if (w_cap) begin
            r_byp_valid <= r_we & ~flush;
            if (!flush) begin
                r_byp_rd   <= r_rd;
                r_byp_data <= r_data;
            end
        end
    end

    assign byp_valid = r_byp_valid;
    assign byp_rd    = r_byp_rd;
    assign byp_data  = r_byp_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage at XLEN=32 with hand-computed results.
module tb_wb_stage;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int SEL_W   = 2;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               stall;
    logic               flush;
    logic [SEL_W-1:0]   wb_sel;
    logic [2:0]         load_type;
    logic [2:0]         addr_lsb;
    logic [XLEN-1:0]    read_data;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] rd_in;
    logic               reg_write_in;
    logic               wb_valid;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               misalign;
`ifdef WB_BYPASS_EN
    logic               byp_valid;
    logic [RADDR_W-1:0] byp_rd;
    logic [XLEN-1:0]    byp_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    wb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .SEL_W(SEL_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .wb_sel       (wb_sel),
        .load_type    (load_type),
        .addr_lsb     (addr_lsb),
        .read_data    (read_data),
        .alu_result   (alu_result),
        .pc_plus4     (pc_plus4),
        .imm          (imm),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign     (misalign)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid    (byp_valid),
        .byp_rd       (byp_rd),
        .byp_data     (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [2:0] lt, input logic [2:0] lsb,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [4:0] rd, input logic rw);
        in_valid     = 1'b1;
        wb_sel       = sel;
        load_type    = lt;
        addr_lsb     = lsb;
        read_data    = rdata;
        alu_result   = alu;
        rd_in        = rd;
        reg_write_in = rw;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic we,
                           input logic [4:0] rd, input logic [31:0] d, input logic ma);
        chk({tag, ".valid"}, 64'(wb_valid), 64'(v));
        chk({tag, ".we"},    64'(wb_we),    64'(we));
        chk({tag, ".rd"},    64'(wb_rd),    64'(rd));
        chk({tag, ".data"},  64'(wb_data),  64'(d));
        chk({tag, ".mis"},   64'(misalign), 64'(ma));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        wb_sel = '0; load_type = '0; addr_lsb = '0; read_data = '0;
        alu_result = '0; pc_plus4 = '0; imm = '0; rd_in = '0; reg_write_in = 1'b0;
        step(); step();
        chk_out("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // ALU write
        drive(2'd0, 3'd0, 3'd0, 32'h0, 32'hDEAD_BEEF, 5'd3, 1'b1);
        step(); chk_out("alu", 1, 1, 3, 32'hDEAD_BEEF, 0);

        // Async reset mid-cycle with a valid instruction at the inputs
        drive(2'd0, 3'd0, 3'd0, 32'h0, 32'h1111_2222, 5'd6, 1'b1);
        #3 rst_n = 1'b0;
        #1 chk_out("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_out("rst_hold", 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step(); chk_out("post_rst", 1, 1, 6, 32'h1111_2222, 0);

        // Sub-word loads
        drive(2'd1, 3'd0, 3'd3, 32'h80FF_FF00, 32'h0, 5'd7, 1'b1);
        step(); chk_out("lb", 1, 1, 7, 32'hFFFF_FF80, 0);
        drive(2'd1, 3'd3, 3'd3, 32'h80FF_FF00, 32'h0, 5'd7, 1'b1);
        step(); chk_out("lbu", 1, 1, 7, 32'h0000_0080, 0);
        drive(2'd1, 3'd1, 3'd1, 32'h7FFF_0000, 32'h0, 5'd8, 1'b1);
        step(); chk("lh_mis.we", 64'(wb_we), 64'(0)); chk("lh_mis.mis", 64'(misalign), 64'(1));
        drive(2'd1, 3'd1, 3'd2, 32'h7FFF_0000, 32'h0, 5'd8, 1'b1);
        step(); chk_out("lh", 1, 1, 8, 32'h0000_7FFF, 0);
        drive(2'd1, 3'd1, 3'd0, 32'h1234_8001, 32'h0, 5'd8, 1'b1);
        step(); chk_out("lh_neg", 1, 1, 8, 32'hFFFF_8001, 0);
        drive(2'd1, 3'd4, 3'd2, 32'h8001_0000, 32'h0, 5'd9, 1'b1);
        step(); chk_out("lhu", 1, 1, 9, 32'h0000_8001, 0);
        drive(2'd1, 3'd2, 3'd0, 32'h8765_4321, 32'h0, 5'd10, 1'b1);
        step(); chk_out("lw", 1, 1, 10, 32'h8765_4321, 0);
        drive(2'd1, 3'd2, 3'd2, 32'h8765_4321, 32'h0, 5'd10, 1'b1);
        step(); chk("lw_mis.we", 64'(wb_we), 64'(0)); chk("lw_mis.mis", 64'(misalign), 64'(1));
        drive(2'd1, 3'd5, 3'd0, 32'hCAFE_F00D, 32'h0, 5'd11, 1'b1);
        step(); chk_out("ld_rv32", 1, 0, 11, 32'h0, 0);
        drive(2'd1, 3'd7, 3'd0, 32'hCAFE_F00D, 32'h0, 5'd12, 1'b1);
        step(); chk_out("lt7", 1, 0, 12, 32'h0, 0);

        // Non-load sources; misaligned-looking load fields must not matter
        drive(2'd2, 3'd1, 3'd1, 32'h0, 32'h0, 5'd0, 1'b1);
        pc_plus4 = 32'h104;
        step(); chk_out("pc4_x0", 1, 0, 0, 32'h104, 0);
        drive(2'd3, 3'd2, 3'd3, 32'h0, 32'h0, 5'd9, 1'b1);
        imm = 32'hABCD_E000;
        step(); chk_out("imm", 1, 1, 9, 32'hABCD_E000, 0);
        drive(2'd0, 3'd0, 3'd0, 32'h0, 32'h77, 5'd13, 1'b0);
        step(); chk_out("no_rw", 1, 0, 13, 32'h77, 0);

        // Bubbles: in_valid low, then flush
        drive(2'd0, 3'd0, 3'd0, 32'h0, 32'h99, 5'd14, 1'b1);
        in_valid = 1'b0;
        step(); chk("bub.valid", 64'(wb_valid), 64'(0)); chk("bub.we", 64'(wb_we), 64'(0));
        chk("bub.data", 64'(wb_data), 64'(32'h77));
        in_valid = 1'b1; flush = 1'b1;
        step(); chk("flush.valid", 64'(wb_valid), 64'(0)); chk("flush.data", 64'(wb_data), 64'(32'h77));
        flush = 1'b0;

        // Stall holds for 3 cycles while inputs change, then flush+stall bubbles
        drive(2'd0, 3'd0, 3'd0, 32'h0, 32'h55, 5'd4, 1'b1);
        step(); chk_out("pre_stall", 1, 1, 4, 32'h55, 0);
        chk("ready", 64'(in_ready), 64'(1));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'd0, 3'd0, 3'd0, 32'h0, 32'h600 + i, 5'd20 + 5'(i), 1'b1);
            #1 chk("stall.ready", 64'(in_ready), 64'(0));
            step(); chk_out("stall", 1, 1, 4, 32'h55, 0);
        end
        flush = 1'b1;
        step(); chk("sf.valid", 64'(wb_valid), 64'(0)); chk("sf.we", 64'(wb_we), 64'(0));
        chk("sf.data", 64'(wb_data), 64'(32'h55));
        stall = 1'b0; flush = 1'b0;

`ifdef WB_BYPASS_EN
        drive(2'd0, 3'd0, 3'd0, 32'h0, 32'h1234, 5'd5, 1'b1);
        step(); chk("byp.we", 64'(wb_we), 64'(1));
        in_valid = 1'b0;
        step();
        chk("byp.valid", 64'(byp_valid), 64'(1));
        chk("byp.rd", 64'(byp_rd), 64'(5));
        chk("byp.data", 64'(byp_data), 64'(32'h1234));
        step(); chk("byp.clr", 64'(byp_valid), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised write-back stage for the 5-stage pipeline.
- Registers the MEM/WB boundary and selects the write-back source from ALU result, load data, PC+4 or immediate.
- Aligns and sign/zero-extends sub-word loads and drives the register-file write port.
- Sits between the data-memory stage and the register file; also feeds the forwarding unit.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- RADDR_W, 5, register-file address width.
- SEL_W, 2, width of the write-back source select.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents a valid instruction
- in_ready  out  1  stage can accept; equals !stall
- stall  in  1  hazard unit freezes the stage
- flush  in  1  squash the instruction being captured
- wb_sel  in  SEL_W  source: 0 ALU, 1 load, 2 PC+4, 3 immediate
- load_type  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 LD (XLEN=64 only)
- addr_lsb  in  3  low byte-address bits of the load
- read_data  in  XLEN  raw word from data memory
- alu_result  in  XLEN  ALU output
- pc_plus4  in  XLEN  link value
- imm  in  XLEN  upper-immediate value
- rd_in  in  RADDR_W  destination register
- reg_write_in  in  1  instruction writes rd
- wb_valid  out  1  registered instruction is valid
- wb_we  out  1  register-file write enable
- wb_rd  out  RADDR_W  register-file write address
- wb_data  out  XLEN  register-file write data
- misalign  out  1  registered load was misaligned

Behaviour:
- Reset (async, rst_n=0): wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, misalign=0. Outputs stay at these values until the first capture after rst_n rises.
- Capture: on a rising clk edge with stall=0, inputs are registered. Latency is one cycle from MEM inputs to wb_* outputs. Source select and load extraction are combinational ahead of the register.
- Stall: while stall=1, all registers hold and in_ready=0. wb_we stays at its held value; the register file treats the repeated write as idempotent.
- Flush: flush=1 with stall=0 captures a bubble: wb_valid=0, wb_we=0, wb_data unchanged.
- Flush and stall together: flush wins; a bubble is captured.
- in_valid=0 with stall=0: a bubble is captured.
- wb_we = wb_valid & reg_write & (rd != 0). A write to x0 never asserts wb_we, but wb_data is still updated.
- Load extraction:
  - The byte or half is selected by addr_lsb from read_data.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW passes through at XLEN=32 and sign-extends bits 31:0 at XLEN=64.
  - Load type 5 at XLEN=32, or types 6/7, yields 0 and no write.
- Misalign: asserted for LH/LHU with addr_lsb[0]=1, LW with addr_lsb[1:0]!=0, or LD with addr_lsb!=0. In that case wb_we is forced to 0 and misalign=1 for that instruction's cycle. wb_sel != 1 never raises misalign.
- wb_sel=3 passes imm unchanged.
- Reset asserted mid-stall clears everything; the stall state is not remembered.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, adds a second register stage holding the previous committed write. It drives extra outputs byp_valid, byp_rd, byp_data, loaded from wb_we/wb_rd/wb_data one cycle later, so the forwarding unit can cover the register-file write-then-read hazard. These registers reset to 0 and obey stall and flush like the main stage.
- When undefined, those ports and registers do not exist; the register file must be write-first.

Decomposition:
- Shared package pipe_pkg holds the wb_sel encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM), the load_type encodings (LD_B, LD_H, LD_W, LD_BU, LD_HU, LD_D) and XLEN_DEFAULT.
- Sub-module load_align, purely combinational, holds load_type/addr_lsb/read_data to extended data plus the misalign flag.
- wb_stage instantiates load_align, then the select mux and the pipeline register.

Test Plan:
- Reset with rst_n=0 mid-cycle while in_valid=1 → all outputs 0 immediately (no clock edge needed); first capture only after rst_n=1.
- LB at addr_lsb=3, read_data=0x80FF_FF00, rd=7 → next cycle wb_data=0xFFFF_FF80, wb_we=1, wb_rd=7. Repeat as LBU → wb_data=0x0000_0080.
- LH at addr_lsb=1 → misalign=1, wb_we=0. LH at addr_lsb=2 with read_data=0x7FFF_0000 → wb_data=0x0000_7FFF.
- wb_sel=2, pc_plus4=0x104, rd=0 → wb_valid=1, wb_data=0x104, wb_we=0.
- stall=1 for 3 cycles while the inputs change → wb_* hold the pre-stall values and in_ready=0. Then flush=1 together with stall=1 → a bubble is captured (wb_valid=0).
- With WB_BYPASS_EN: ALU write of 0x1234 to rd=5 → byp_rd=5, byp_data=0x1234, byp_valid=1 one cycle after wb_we; the build without the macro still passes all other tests.
